mc_stream_client: RTL and testbench



---
 rtl/mc_stream_pkg.sv | 28 ++
 rtl/mc_stream_client_if.sv | 13 +
 rtl/bsg_two_fifo.sv | 69 ++++++
 rtl/mc_stream_client.sv | 145 ++++++++++++++
 tb/tb_mc_stream_client.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_stream_pkg.sv
// Shared definitions for the manycore stream host and its host-side client:
// well-known stream addresses, the NBF loader record layout and the client FSM states.
package mc_stream_pkg;

    localparam logic [31:0] NBF_ADDR  = 32'h10;
    localparam logic [31:0] MMIO_ADDR = 32'h20;

    // 128-bit loader record; data sits in the least significant word, so it is streamed first.
    typedef struct packed {
        logic [31:0] opcode;
        logic [15:0] y;
        logic [15:0] x;
        logic [31:0] addr;
        logic [31:0] data;
    } nbf_rec_s;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND_NBF  = 2'd1,
        ST_SEND_MMIO = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_NBF  = 1'b0,
        GRANT_MMIO = 1'b1
    } grant_e;

endpackage

// File: rtl/mc_stream_client_if.sv
// Addressed valid/yumi stream bundle as seen between the host-side client and the manycore stream host.
interface mc_stream_client_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
);
    logic                    v;
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] data;
    logic                    yumi;

    modport master (output v, addr, data, input yumi);
    modport slave  (input v, addr, data, output yumi);
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry registered FIFO: ready/valid on the input side, valid/yumi on the output side.
module bsg_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               enq, deq;

    assign enq     = v_i & ready_o;
    assign deq     = yumi_i;
    assign ready_o = ~full_q;
    assign v_o     = ~empty_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (enq) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // Occupancy only changes when exactly one side moves.
        if (enq && !deq) begin
            empty_d = 1'b0;
            full_d  = (~wr_ptr_q == rd_ptr_q);
        end else if (deq && !enq) begin
            full_d  = 1'b0;
            empty_d = (~rd_ptr_q == wr_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mc_stream_client.sv
// Host-side stream client: serializes NBF records and MMIO words onto the addressed manycore
// stream and buffers the returning MMIO data.
module mc_stream_client
    import mc_stream_pkg::*;
#(
    parameter int          stream_addr_width_p = 32,
    parameter int          stream_data_width_p = 32,
    parameter int          nbf_width_p         = 128,
    parameter logic [31:0] nbf_addr_p          = NBF_ADDR,
    parameter logic [31:0] mmio_addr_p         = MMIO_ADDR,
    parameter int          cnt_width_p         = 32
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           nbf_v_i,
    input  logic [nbf_width_p-1:0]         nbf_data_i,
    output logic                           nbf_ready_o,

    input  logic                           mmio_v_i,
    input  logic [stream_data_width_p-1:0] mmio_data_i,
    output logic                           mmio_ready_o,

    output logic                           stream_v_o,
    output logic [stream_addr_width_p-1:0] stream_addr_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,

    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o,

    output logic                           resp_v_o,
    output logic [stream_data_width_p-1:0] resp_data_o,
    input  logic                           resp_yumi_i,

    output logic [cnt_width_p-1:0]         nbf_sent_o,
    output logic                           idle_o,
    output logic [1:0]                     state_o
);
    localparam int words_lp  = nbf_width_p / stream_data_width_p;
    localparam int wcnt_w_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam logic [wcnt_w_lp-1:0] last_word_lp = wcnt_w_lp'(words_lp - 1);

    state_e                          state_q, state_d;
    logic [nbf_width_p-1:0]          shift_q, shift_d;
    logic [stream_data_width_p-1:0]  mmio_q, mmio_d;
    logic [wcnt_w_lp-1:0]            word_cnt_q, word_cnt_d;
    logic [cnt_width_p-1:0]          sent_q, sent_d;
    grant_e                          last_grant_q, last_grant_d;
    logic                            grant_nbf, grant_mmio;

    // Round-robin between the two request classes; a lone request always wins.
    assign grant_nbf  = nbf_v_i & (~mmio_v_i | (last_grant_q == GRANT_MMIO));
    assign grant_mmio = mmio_v_i & ~grant_nbf;

    // Outgoing stream: a word moves on any cycle with stream_v_o & stream_yumi_i; stream_v_o
    // depends on state only, and addr/data stay stable until the word is taken.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        mmio_d        = mmio_q;
        word_cnt_d    = word_cnt_q;
        sent_d        = sent_q;
        last_grant_d  = last_grant_q;
        nbf_ready_o   = 1'b0;
        mmio_ready_o  = 1'b0;
        stream_v_o    = 1'b0;
        stream_addr_o = '0;
        stream_data_o = '0;
        case (state_q)
            ST_IDLE: begin
                nbf_ready_o  = ~grant_mmio;
                mmio_ready_o = ~grant_nbf;
                if (grant_nbf) begin
                    shift_d      = nbf_data_i;
                    word_cnt_d   = '0;
                    last_grant_d = GRANT_NBF;
                    state_d      = ST_SEND_NBF;
                end else if (grant_mmio) begin
                    mmio_d       = mmio_data_i;
                    last_grant_d = GRANT_MMIO;
                    state_d      = ST_SEND_MMIO;
                end
            end
            ST_SEND_NBF: begin
                stream_v_o    = 1'b1;
                stream_addr_o = stream_addr_width_p'(nbf_addr_p);
                stream_data_o = shift_q[stream_data_width_p-1:0];
                if (stream_yumi_i) begin
                    shift_d    = shift_q >> stream_data_width_p;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == last_word_lp) begin
                        word_cnt_d = '0;
                        sent_d     = sent_q + 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_SEND_MMIO: begin
                stream_v_o    = 1'b1;
                stream_addr_o = stream_addr_width_p'(mmio_addr_p);
                stream_data_o = mmio_q;
                if (stream_yumi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            mmio_q       <= '0;
            word_cnt_q   <= '0;
            sent_q       <= '0;
            last_grant_q <= GRANT_MMIO;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            mmio_q       <= mmio_d;
            word_cnt_q   <= word_cnt_d;
            sent_q       <= sent_d;
            last_grant_q <= last_grant_d;
        end
    end

    bsg_two_fifo #(.width_p(stream_data_width_p)) ret_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (stream_ready_o),
        .data_i  (stream_data_i),
        .v_i     (stream_v_i),
        .v_o     (resp_v_o),
        .data_o  (resp_data_o),
        .yumi_i  (resp_yumi_i)
    );

    assign nbf_sent_o = sent_q;
    assign idle_o     = (state_q == ST_IDLE) & ~resp_v_o;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mc_stream_client.sv
// Bench for mc_stream_client: directed timing sequences, an arbitration vector table and
// randomized backpressure, with scoreboards on the outgoing and return streams.
module tb_mc_stream_client;
    import mc_stream_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 128;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            nbf_v_i;
    logic [NW-1:0]   nbf_data_i;
    logic            nbf_ready_o;
    logic            mmio_v_i;
    logic [DW-1:0]   mmio_data_i;
    logic            mmio_ready_o;
    logic            stream_v_i;
    logic [DW-1:0]   stream_data_i;
    logic            stream_ready_o;
    logic            resp_v_o;
    logic [DW-1:0]   resp_data_o;
    logic            resp_yumi_i;
    logic [CW-1:0]   nbf_sent_o;
    logic            idle_o;
    logic [1:0]      state_o;

    mc_stream_client_if #(.addr_width_p(AW), .data_width_p(DW)) out_if ();

    always #5 clk = ~clk;

    mc_stream_client dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .nbf_v_i        (nbf_v_i),
        .nbf_data_i     (nbf_data_i),
        .nbf_ready_o    (nbf_ready_o),
        .mmio_v_i       (mmio_v_i),
        .mmio_data_i    (mmio_data_i),
        .mmio_ready_o   (mmio_ready_o),
        .stream_v_o     (out_if.v),
        .stream_addr_o  (out_if.addr),
        .stream_data_o  (out_if.data),
        .stream_yumi_i  (out_if.yumi),
        .stream_v_i     (stream_v_i),
        .stream_data_i  (stream_data_i),
        .stream_ready_o (stream_ready_o),
        .resp_v_o       (resp_v_o),
        .resp_data_o    (resp_data_o),
        .resp_yumi_i    (resp_yumi_i),
        .nbf_sent_o     (nbf_sent_o),
        .idle_o         (idle_o),
        .state_o        (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] ret_q[$];
    int yumi_mode = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check64(name, {63'd0, act}, {63'd0, exp});
    endtask

    // Yumi driver: 0 = take every word, 1 = random stalls, 2 = driven by the test.
    always @(negedge clk) begin
        #1;
        if (yumi_mode == 0)
            out_if.yumi = out_if.v & ~reset_i;
        else if (yumi_mode == 1)
            out_if.yumi = out_if.v & ~reset_i & ($urandom_range(0, 3) != 0);
    end

    logic        prev_v = 1'b0, prev_yumi = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(negedge clk) begin
        #2;
        if (!reset_i && !prev_rst && prev_v && !prev_yumi) begin
            check1("stall_v_held", out_if.v, 1'b1);
            check64("stall_word_held", {out_if.addr, out_if.data}, {prev_addr, prev_data});
        end
        if (out_if.v && out_if.yumi && !reset_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stream_word: got unexpected %h/%h expected none", out_if.addr, out_if.data);
            end else begin
                check64("stream_word", {out_if.addr, out_if.data}, exp_q.pop_front());
            end
        end
        if (resp_v_o && resp_yumi_i) begin
            if (ret_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_word: got unexpected %h expected none", resp_data_o);
            end else begin
                check64("resp_word", {32'd0, resp_data_o}, {32'd0, ret_q.pop_front()});
            end
        end
        prev_v    = out_if.v;
        prev_yumi = out_if.yumi;
        prev_rst  = reset_i;
        prev_addr = out_if.addr;
        prev_data = out_if.data;
    end

    task automatic push_record(input logic [NW-1:0] r, input int nwords);
        for (int k = 0; k < nwords; k++) exp_q.push_back({32'h10, r[k*32 +: 32]});
    endtask

    task automatic push_mmio(input logic [31:0] w);
        exp_q.push_back({32'h20, w});
    endtask

    task automatic wait_idle(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #3;
            if (idle_o) begin
                seen = 1'b1;
                break;
            end
        end
        check1(name, seen, 1'b1);
    endtask

    task automatic send_nbf(input logic [NW-1:0] r);
        logic got;
        got = 1'b0;
        @(negedge clk);
        nbf_v_i    = 1'b1;
        nbf_data_i = r;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (nbf_ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check1("nbf_accept", got, 1'b1);
        if (got) push_record(r, 4);
        @(posedge clk);
        #1;
        nbf_v_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i       = 1'b1;
        nbf_v_i       = 1'b0;
        mmio_v_i      = 1'b0;
        stream_v_i    = 1'b0;
        resp_yumi_i   = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
    endtask

    typedef struct {
        logic          nv;
        logic          mv;
        logic [NW-1:0] nd;
        logic [31:0]   md;
        int            exp_grant;  // 0 none, 1 NBF, 2 MMIO
        logic          exp_nr;
        logic          exp_mr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NW-1:0] rec;
        nbf_rec_s      rs;
        logic [31:0]   fw [3];
        int            exp_sent;
        int            grants;

        vecs[0] = '{1'b1, 1'b0, {32'h11, 32'h12, 32'h13, 32'h14}, 32'h0,        1, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, '0,                                 32'hC0DE_0001, 2, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, {32'h21, 32'h22, 32'h23, 32'h24}, 32'hC0DE_0002, 1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, {32'h31, 32'h32, 32'h33, 32'h34}, 32'hC0DE_0003, 2, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, {32'h41, 32'h42, 32'h43, 32'h44}, 32'hC0DE_0004, 1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, '0,                                 32'hC0DE_0005, 2, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, {32'h71, 32'h72, 32'h73, 32'h74}, 32'hC0DE_0006, 1, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, '0,                                 32'h0,        0, 1'b1, 1'b1};

        reset_i       = 1'b1;
        nbf_v_i       = 1'b0;
        nbf_data_i    = '0;
        mmio_v_i      = 1'b0;
        mmio_data_i   = '0;
        stream_v_i    = 1'b0;
        stream_data_i = '0;
        resp_yumi_i   = 1'b0;
        out_if.yumi   = 1'b0;
        exp_sent      = 0;

        // Reset state
        do_reset();
        @(negedge clk);
        #1;
        check1("rst_stream_v", out_if.v, 1'b0);
        check64("rst_addr_data", {out_if.addr, out_if.data}, 64'd0);
        check64("rst_nbf_sent", {32'd0, nbf_sent_o}, 64'd0);
        check1("rst_resp_v", resp_v_o, 1'b0);
        check1("rst_stream_ready", stream_ready_o, 1'b1);
        check1("rst_idle", idle_o, 1'b1);
        check64("rst_state", {62'd0, state_o}, 64'd0);
        check1("rst_nbf_ready", nbf_ready_o, 1'b1);
        check1("rst_mmio_ready", mmio_ready_o, 1'b1);

        // Single record, yumi always high: words 4,3,2,1 then IDLE at t+5
        rs  = '{opcode: 32'h1, y: 16'h0, x: 16'h2, addr: 32'h3, data: 32'h4};
        rec = rs;
        @(negedge clk);
        nbf_v_i    = 1'b1;
        nbf_data_i = rec;
        #1;
        check1("single_nbf_ready", nbf_ready_o, 1'b1);
        check1("single_mmio_ready_masked", mmio_ready_o, 1'b0);
        push_record(rec, 4);
        @(posedge clk);
        #1;
        nbf_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check1("single_v", out_if.v, 1'b1);
            check64("single_word", {out_if.addr, out_if.data}, {32'h10, 32'(4 - k)});
            check1("single_busy_ready", nbf_ready_o, 1'b0);
        end
        @(negedge clk);
        #1;
        check1("single_v_done", out_if.v, 1'b0);
        check1("single_ready_again", nbf_ready_o, 1'b1);
        check64("single_sent", {32'd0, nbf_sent_o}, 64'd1);
        exp_sent = 1;

        // MMIO word with yumi delayed three cycles
        yumi_mode   = 2;
        out_if.yumi = 1'b0;
        @(negedge clk);
        mmio_v_i    = 1'b1;
        mmio_data_i = 32'hDEAD_BEEF;
        push_mmio(32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        mmio_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check1("mmio_v", out_if.v, 1'b1);
            check64("mmio_word", {out_if.addr, out_if.data}, {32'h20, 32'hDEAD_BEEF});
            if (k == 3) out_if.yumi = 1'b1;
        end
        @(posedge clk);
        #1;
        out_if.yumi = 1'b0;
        @(negedge clk);
        #1;
        check1("mmio_v_done", out_if.v, 1'b0);
        check1("mmio_idle", idle_o, 1'b1);
        yumi_mode = 0;

        // Arbitration vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nbf_v_i     = vecs[i].nv;
            nbf_data_i  = vecs[i].nd;
            mmio_v_i    = vecs[i].mv;
            mmio_data_i = vecs[i].md;
            #1;
            check1("tbl_nbf_ready", nbf_ready_o, vecs[i].exp_nr);
            check1("tbl_mmio_ready", mmio_ready_o, vecs[i].exp_mr);
            if (vecs[i].exp_grant == 1) begin
                push_record(vecs[i].nd, 4);
                exp_sent++;
            end else if (vecs[i].exp_grant == 2) begin
                push_mmio(vecs[i].md);
            end
            @(posedge clk);
            #1;
            nbf_v_i  = 1'b0;
            mmio_v_i = 1'b0;
            wait_idle("tbl_idle");
        end
        check64("tbl_sent", {32'd0, nbf_sent_o}, 64'(exp_sent));

        // Both held valid: grants alternate MMIO, NBF, ... with no interleaving
        rec = {32'hAAAA_0004, 32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
        @(negedge clk);
        nbf_v_i     = 1'b1;
        nbf_data_i  = rec;
        mmio_v_i    = 1'b1;
        mmio_data_i = 32'h5555_AAAA;
        grants      = 0;
        for (int c = 0; c < 200 && grants < 6; c++) begin
            #1;
            if (nbf_ready_o || mmio_ready_o) begin
                check1("alt_grant_nbf", nbf_ready_o, (grants % 2) == 1);
                if ((grants % 2) == 1) begin
                    push_record(rec, 4);
                    exp_sent++;
                end else begin
                    push_mmio(32'h5555_AAAA);
                end
                grants++;
                if (grants == 6) begin
                    @(posedge clk);
                    #1;
                    nbf_v_i  = 1'b0;
                    mmio_v_i = 1'b0;
                end
            end
            if (grants < 6) @(negedge clk);
        end
        check64("alt_grant_count", 64'(grants), 64'd6);
        wait_idle("alt_idle");
        check64("alt_sent", {32'd0, nbf_sent_o}, 64'(exp_sent));

        // 50 records under random backpressure
        do_reset();
        yumi_mode = 1;
        for (int i = 0; i < 50; i++) send_nbf({$urandom(), $urandom(), $urandom(), $urandom()});
        wait_idle("rand_idle");
        check64("rand_sent", {32'd0, nbf_sent_o}, 64'd50);
        yumi_mode = 0;

        // Return path: three pushes with no consumer
        fw[0] = 32'hA000_0001;
        fw[1] = 32'hA000_0002;
        fw[2] = 32'hA000_0003;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stream_v_i    = 1'b1;
            stream_data_i = fw[i];
            #1;
            check1("ret_ready", stream_ready_o, i < 2);
            if (i == 1) check1("ret_resp_v_t1", resp_v_o, 1'b1);
            if (stream_ready_o) ret_q.push_back(fw[i]);
        end
        @(negedge clk);
        stream_v_i = 1'b0;
        #1;
        check1("ret_full_ready", stream_ready_o, 1'b0);
        check1("ret_not_idle", idle_o, 1'b0);
        check64("ret_head", {32'd0, resp_data_o}, {32'd0, fw[0]});
        resp_yumi_i = 1'b1;
        @(negedge clk);
        #1;
        check1("ret_second_v", resp_v_o, 1'b1);
        @(negedge clk);
        resp_yumi_i = 1'b0;
        #1;
        check1("ret_drained_v", resp_v_o, 1'b0);
        check1("ret_drained_ready", stream_ready_o, 1'b1);

        // Reset after word 2 of a record drops the remainder
        rec = {32'hBEEF_0004, 32'hBEEF_0003, 32'hBEEF_0002, 32'hBEEF_0001};
        @(negedge clk);
        nbf_v_i    = 1'b1;
        nbf_data_i = rec;
        push_record(rec, 2);
        @(posedge clk);
        #1;
        nbf_v_i = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check1("midrst_v", out_if.v, 1'b0);
        check64("midrst_sent", {32'd0, nbf_sent_o}, 64'd0);
        rec = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
        send_nbf(rec);
        wait_idle("midrst_idle");
        check64("midrst_sent_after", {32'd0, nbf_sent_o}, 64'd1);

        repeat (3) @(negedge clk);
        check64("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check64("ret_q_drained", 64'(ret_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
